// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them to instruction memory, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (adds the CHK state).
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    WORD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    FLUSH,
    RUN,
    ERR
  } state_t;

  localparam logic [16:0]         CAP     = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

  state_t                state, state_next;
  logic [15:0]           count;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [23:0]           shift;
  logic                  xfer;
  logic [15:0]           len_n;
  logic [16:0]           idx_next;
  logic                  last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_xor;
`endif

  assign s_ready   = (state == LEN0) || (state == LEN1) || (state == WORD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state == CHK)
`endif
                     ;
  assign core_rst  = (state != RUN);
  assign done      = (state == RUN);
  assign error     = (state == ERR);
  assign xfer      = s_valid && s_ready;
  assign len_n     = {s_data, count[7:0]};
  assign idx_next  = 17'(word_idx) + 17'd1;
  assign last_word = (idx_next == {1'b0, count});

  always_ff @(posedge clk) begin
    if (rst) state <= LEN0;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LEN0: if (xfer) state_next = LEN1;
      LEN1: begin
        if (xfer) begin
          if (len_n == 16'd0)             state_next = FLUSH;
          else if ({1'b0, len_n} > CAP)   state_next = ERR;
          else                            state_next = WORD;
        end
      end
      WORD: begin
        if (xfer && (byte_cnt == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = FLUSH;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:  if (xfer) state_next = (s_data == chk_xor) ? FLUSH : ERR;
`endif
      FLUSH: state_next = RUN;
      RUN:   if (reload) state_next = LEN0;
      ERR:   if (reload) state_next = LEN0;
      default: state_next = LEN0;
    endcase
  end

  // Word assembly and the one-cycle write strobe; the write is registered so it lands the cycle after the 4th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_xor    <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        case (state)
          LEN0: begin
            count[7:0] <= s_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_xor    <= s_data;
`endif
          end
          LEN1: begin
            count[15:8] <= s_data;
            byte_cnt    <= '0;
            word_idx    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_xor     <= chk_xor ^ s_data;
`endif
          end
          WORD: begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_xor  <= chk_xor ^ s_data;
`endif
            case (byte_cnt)
              2'd0: shift[7:0]   <= s_data;
              2'd1: shift[15:8]  <= s_data;
              2'd2: shift[23:16] <= s_data;
              default: begin
                imem_wdata <= {s_data, shift};
                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                imem_we    <= 1'b1;
                word_idx   <= word_idx + IDX_ONE;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=8); follows the checksum build when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  int          assert_count = 0;
  int          fail_count   = 0;
  int          wr_count     = 0;
  int          wr_base;
  logic [7:0]  last_addr    = 8'h00;
  logic [7:0]  tb_xor;
  logic [31:0] mem [0:255];

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Behaves like the instruction memory: captures every strobed write.
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      wr_count       = wr_count + 1;
      last_addr      = imem_addr;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tb_xor  = tb_xor ^ b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic startStream(input logic [15:0] n);
    tb_xor = 8'h00;
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    applyStimulus(w[31:24]);
  endtask

  task automatic endStream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(tb_xor);
`endif
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  function automatic logic [31:0] fillWord(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5A, b};
  endfunction

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    reload  = 1'b0;
    tb_xor  = 8'h00;
    idleCycles(2);

    // Reset values
    checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // Single word: addi x1,x0,1
    wr_base = wr_count;
    startStream(16'd1);
    sendWord(32'h00100093);
    checkOutput("a_we", 32'(imem_we), 32'd1);
    checkOutput("a_addr", 32'(imem_addr), 32'd0);
    checkOutput("a_wdata", imem_wdata, 32'h00100093);
    endStream();
    checkOutput("a_flush_core_rst", 32'(core_rst), 32'd1);
    checkOutput("a_flush_s_ready", 32'(s_ready), 32'd0);
    idleCycles(1);
    checkOutput("a_run_core_rst", 32'(core_rst), 32'd0);
    checkOutput("a_run_done", 32'(done), 32'd1);
    checkOutput("a_writes", 32'(wr_count - wr_base), 32'd1);

    // Bytes offered in RUN are ignored
    applyStimulus(8'hEE);
    idleCycles(1);
    checkOutput("run_ignore_done", 32'(done), 32'd1);
    checkOutput("run_ignore_writes", 32'(wr_count - wr_base), 32'd1);

    pulseReload();
    checkOutput("reload_core_rst", 32'(core_rst), 32'd1);
    checkOutput("reload_done", 32'(done), 32'd0);
    checkOutput("reload_s_ready", 32'(s_ready), 32'd1);

    // Three words with a 5-cycle stall inside word 1
    wr_base = wr_count;
    startStream(16'd3);
    sendWord(32'h44332211);
    checkOutput("b_w0_addr", 32'(imem_addr), 32'd0);
    checkOutput("b_w0_data", imem_wdata, 32'h44332211);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    idleCycles(5);
    checkOutput("b_gap_s_ready", 32'(s_ready), 32'd1);
    checkOutput("b_gap_we", 32'(imem_we), 32'd0);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    checkOutput("b_w1_we", 32'(imem_we), 32'd1);
    checkOutput("b_w1_addr", 32'(imem_addr), 32'd1);
    checkOutput("b_w1_data", imem_wdata, 32'h88776655);
    sendWord(32'hDDCCBBAA);
    checkOutput("b_w2_addr", 32'(imem_addr), 32'd2);
    checkOutput("b_w2_data", imem_wdata, 32'hDDCCBBAA);
    endStream();
    idleCycles(3);
    checkOutput("b_done", 32'(done), 32'd1);
    checkOutput("b_writes", 32'(wr_count - wr_base), 32'd3);
    checkOutput("b_mem1", mem[1], 32'h88776655);

    // Count 257 overflows a 256-word memory
    pulseReload();
    startStream(16'h0101);
    checkOutput("c_error", 32'(error), 32'd1);
    checkOutput("c_s_ready", 32'(s_ready), 32'd0);
    checkOutput("c_core_rst", 32'(core_rst), 32'd1);
    idleCycles(2);
    checkOutput("c_core_rst_held", 32'(core_rst), 32'd1);
    pulseReload();
    checkOutput("c_reload_s_ready", 32'(s_ready), 32'd1);
    checkOutput("c_reload_error", 32'(error), 32'd0);

    // Full memory: 256 words
    wr_base = wr_count;
    startStream(16'd256);
    for (int i = 0; i < 256; i++) sendWord(fillWord(i));
    checkOutput("d_last_we", 32'(imem_we), 32'd1);
    checkOutput("d_last_addr", 32'(imem_addr), 32'hFF);
    checkOutput("d_last_data", imem_wdata, 32'hFF005AFF);
    endStream();
    checkOutput("d_flush_s_ready", 32'(s_ready), 32'd0);
    idleCycles(1);
    checkOutput("d_done", 32'(done), 32'd1);
    idleCycles(3);
    checkOutput("d_writes", 32'(wr_count - wr_base), 32'd256);
    checkOutput("d_final_addr", 32'(last_addr), 32'hFF);
    checkOutput("d_mem0", mem[0], 32'h00FF5A00);
    checkOutput("d_mem128", mem[128], 32'h807F5A80);
    checkOutput("d_mem255", mem[255], 32'hFF005AFF);

    // Reset in the middle of word 1, then a clean single-word image
    pulseReload();
    startStream(16'd2);
    sendWord(32'h04030201);
    checkOutput("e_w0_data", imem_wdata, 32'h04030201);
    applyStimulus(8'h05);
    applyStimulus(8'h06);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkOutput("e_rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("e_rst_core_rst", 32'(core_rst), 32'd1);
    checkOutput("e_rst_wdata", imem_wdata, 32'd0);
    checkOutput("e_rst_addr", 32'(imem_addr), 32'd0);
    wr_base = wr_count;
    startStream(16'd1);
    sendWord(32'h12345678);
    checkOutput("e_we", 32'(imem_we), 32'd1);
    checkOutput("e_addr", 32'(imem_addr), 32'd0);
    checkOutput("e_data", imem_wdata, 32'h12345678);
    endStream();
    idleCycles(2);
    checkOutput("e_done", 32'(done), 32'd1);
    checkOutput("e_writes", 32'(wr_count - wr_base), 32'd1);
    checkOutput("e_mem1_kept", mem[1], 32'h01FE5A01);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accepted, then rejected
    pulseReload();
    startStream(16'd1);
    sendWord(32'h00A00513);
    applyStimulus(8'hB7);
    idleCycles(1);
    checkOutput("f_good_done", 32'(done), 32'd1);
    checkOutput("f_good_core_rst", 32'(core_rst), 32'd0);
    pulseReload();
    startStream(16'd1);
    sendWord(32'h00A00513);
    applyStimulus(8'h00);
    checkOutput("f_bad_error", 32'(error), 32'd1);
    checkOutput("f_bad_core_rst", 32'(core_rst), 32'd1);
    checkOutput("f_bad_mem0", mem[0], 32'h00A00513);
    pulseReload();
    checkOutput("f_reload_s_ready", 32'(s_ready), 32'd1);
    checkOutput("f_reload_core_rst", 32'(core_rst), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
